// File: rtl/b_digit_feeder_pkg.sv
// Shared constants, FSM state encoding and operand padding helper for the
// GF(2^163) B-operand digit feeder.
package b_digit_feeder_pkg;

    localparam int M      = 163;
    localparam int DIGITS = 16;
    localparam int NDIG   = 11;
    localparam int PAD_W  = NDIG * DIGITS;
    localparam int CNT_W  = 4;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIG - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Zero-extend an M-bit operand to the padded shift width.
    function automatic logic [PAD_W-1:0] pad_operand(input logic [M-1:0] b);
        return {{(PAD_W - M){1'b0}}, b};
    endfunction

endpackage

// File: rtl/b_digit_feeder_shreg.sv
// b_digit_shreg: padded operand register. Load has priority over shift;
// with neither asserted the contents hold (PE stall).
module b_digit_shreg
    import b_digit_feeder_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [PAD_W-1:0]  load_val_i,
    input  logic              shift_i,
    output logic [DIGITS-1:0] top_digit_o
);

    logic [PAD_W-1:0] sr_q;
    logic [PAD_W-1:0] sr_d;

    // Next contents: load a fresh operand, shift out one digit, or hold.
    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = load_val_i;
        end else if (shift_i) begin
            sr_d = {sr_q[PAD_W-DIGITS-1:0], {DIGITS{1'b0}}};
        end
    end

    // Register with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign top_digit_o = sr_q[PAD_W-1 -: DIGITS];

endmodule

// File: rtl/b_digit_feeder.sv
// b_digit_feeder: accepts a 163-bit B operand and streams it MSB-first as
// eleven 16-bit digits with first/last framing for the systolic PE array.
// Optional build macro FEEDER_PRELOAD_EN adds a one-entry pending operand
// buffer so consecutive operands stream without a gap.
//
// state | meaning
// IDLE  | waiting for an operand, ready high
// SHIFT | operand loaded; one fill cycle, then one digit per unstalled cycle
module b_digit_feeder
    import b_digit_feeder_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              b_valid_in,
    output logic              b_ready_out,
    input  logic [M-1:0]      b_in,
    input  logic              digit_hold_in,
    output logic [DIGITS-1:0] digit_out,
    output logic              digit_valid_out,
    output logic              digit_first_out,
    output logic              digit_last_out,
    output logic              busy_out
);

    state_e             state_q, state_d;
    logic               fill_q, fill_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ready_q, ready_d;
    logic [DIGITS-1:0]  digit_q, digit_d;
    logic               valid_q, valid_d;
    logic               first_q, first_d;
    logic               last_q, last_d;
    logic               busy_q, busy_d;

    logic               sr_load;
    logic               sr_shift;
    logic [PAD_W-1:0]   sr_load_val;
    logic [DIGITS-1:0]  sr_top;
    logic               accept;

`ifdef FEEDER_PRELOAD_EN
    logic [M-1:0]       pend_q, pend_d;
    logic               pend_full_q, pend_full_d;
`endif

    assign accept = b_valid_in & ready_q;

    b_digit_shreg u_shreg (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (sr_load),
        .load_val_i  (sr_load_val),
        .shift_i     (sr_shift),
        .top_digit_o (sr_top)
    );

    // Next-state, shift-register control and registered-output values.
    always_comb begin
        state_d     = state_q;
        fill_d      = fill_q;
        cnt_d       = cnt_q;
        digit_d     = digit_q;
        valid_d     = 1'b0;
        first_d     = 1'b0;
        last_d      = 1'b0;
        sr_load     = 1'b0;
        sr_shift    = 1'b0;
        sr_load_val = pad_operand(b_in);
`ifdef FEEDER_PRELOAD_EN
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    sr_load = 1'b1;
                    cnt_d   = '0;
                    fill_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
`ifdef FEEDER_PRELOAD_EN
                if (accept) begin
                    pend_d      = b_in;
                    pend_full_d = 1'b1;
                end
`endif
                // The fill cycle after a fresh load gives the two-edge
                // accept-to-digit latency; hold does not extend it.
                if (fill_q) begin
                    fill_d = 1'b0;
                end else if (!digit_hold_in) begin
                    digit_d  = sr_top;
                    valid_d  = 1'b1;
                    first_d  = (cnt_q == '0);
                    last_d   = (cnt_q == LAST_CNT);
                    sr_shift = 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
`ifdef FEEDER_PRELOAD_EN
                        // Chain straight into the next operand; an operand
                        // arriving on this very edge bypasses the buffer.
                        if (pend_full_q) begin
                            sr_load     = 1'b1;
                            sr_load_val = pad_operand(pend_q);
                            cnt_d       = '0;
                            pend_full_d = 1'b0;
                        end else if (accept) begin
                            sr_load     = 1'b1;
                            sr_load_val = pad_operand(b_in);
                            cnt_d       = '0;
                            pend_full_d = 1'b0;
                        end else begin
                            state_d = IDLE;
                        end
`else
                        state_d = IDLE;
`endif
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_q == SHIFT) && !fill_q;
`ifdef FEEDER_PRELOAD_EN
        ready_d = !pend_full_d;
`else
        ready_d = (state_d == IDLE);
`endif
    end

    // State, counter and output registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            fill_q  <= 1'b0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            digit_q <= '0;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            digit_q <= digit_d;
            valid_q <= valid_d;
            first_q <= first_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
        end
    end

`ifdef FEEDER_PRELOAD_EN
    // Pending operand buffer; discarded on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q      <= '0;
            pend_full_q <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
        end
    end
`endif

    assign b_ready_out     = ready_q;
    assign digit_out       = digit_q;
    assign digit_valid_out = valid_q;
    assign digit_first_out = first_q;
    assign digit_last_out  = last_q;
    assign busy_out        = busy_q;

endmodule

// File: tb/tb_b_digit_feeder.sv
// Testbench for b_digit_feeder: scoreboard of expected digits filled at each
// accepted handshake, drained by a negedge monitor. Honours FEEDER_PRELOAD_EN.
module tb_b_digit_feeder;

    localparam int M = 163;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          b_valid_in;
    logic          b_ready_out;
    logic [M-1:0]  b_in;
    logic          digit_hold_in;
    logic [15:0]   digit_out;
    logic          digit_valid_out;
    logic          digit_first_out;
    logic          digit_last_out;
    logic          busy_out;

    always #5 clk = ~clk;

    b_digit_feeder dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .b_valid_in      (b_valid_in),
        .b_ready_out     (b_ready_out),
        .b_in            (b_in),
        .digit_hold_in   (digit_hold_in),
        .digit_out       (digit_out),
        .digit_valid_out (digit_valid_out),
        .digit_first_out (digit_first_out),
        .digit_last_out  (digit_last_out),
        .busy_out        (busy_out)
    );

    typedef struct packed {
        logic [15:0] d;
        logic        f;
        logic        l;
    } exp_t;

    exp_t q_exp[$];
    int   acc_q[$];
    int   first_q[$];
    int   last_q[$];
    int   cyc = 0;
    int   vcount = 0;
    int   bcount = 0;
    int   rb_overlap = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: pad B to 176 bits and cut it into 11 digits, MSB first.
    function automatic void push_op(input logic [M-1:0] b);
        logic [175:0] p;
        exp_t e;
        p = 176'(b);
        for (int k = 0; k < 11; k++) begin
            e.d = 16'(p >> (16 * (10 - k)));
            e.f = (k == 0);
            e.l = (k == 10);
            q_exp.push_back(e);
        end
    endfunction

    function automatic logic [M-1:0] rand_b();
        logic [191:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return r[M-1:0];
    endfunction

    // Stimulus side of the scoreboard: every accepted operand queues its digits.
    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            q_exp.delete();
        end else if (b_valid_in && b_ready_out) begin
            push_op(b_in);
            acc_q.push_back(cyc);
        end
    end

    // Monitor: compare every presented digit against the queue head.
    always @(negedge clk) begin : mon
        exp_t e;
        if (busy_out) bcount++;
        if (digit_valid_out && !digit_last_out && b_ready_out) rb_overlap++;
        if (digit_valid_out) begin
            vcount++;
            if (digit_first_out) first_q.push_back(cyc);
            if (digit_last_out) last_q.push_back(cyc);
            if (q_exp.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_digit: got %h with no digit expected (cycle %0d)", digit_out, cyc);
            end else begin
                e = q_exp.pop_front();
                check("digit_first_last", {digit_out, digit_first_out, digit_last_out}, {e.d, e.f, e.l});
            end
        end else begin
            check("flags_when_invalid", {digit_first_out, digit_last_out}, 2'b00);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        acc_q.delete();
        first_q.delete();
        last_q.delete();
        vcount = 0;
        bcount = 0;
        rb_overlap = 0;
    endtask

    // Offer b and return just after the accepting edge, valid still high.
    task automatic accept_one(input logic [M-1:0] b);
        int n;
        n = 0;
        b_in = b;
        b_valid_in = 1'b1;
        while (!b_ready_out && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: ready got 0 required 1");
        end
        tick();
    endtask

    task automatic send(input logic [M-1:0] b);
        accept_one(b);
        b_valid_in = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q_exp.size() != 0 || busy_out || digit_valid_out) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) begin
            n_checks++;
            n_errors++;
            $display("FAIL idle_timeout: pending digits got %0d required 0", q_exp.size());
        end
        repeat (2) tick();
    endtask

    task automatic wait_valid_count(input int target);
        int v;
        int n;
        v = 0;
        n = 0;
        while (v < target && n < 60) begin
            @(negedge clk);
            if (digit_valid_out) v++;
            n++;
        end
        if (v < target) begin
            n_checks++;
            n_errors++;
            $display("FAIL valid_wait_timeout: digits seen %0d required %0d", v, target);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ready"}, b_ready_out, 1'b0);
        check({tag, "_valid"}, digit_valid_out, 1'b0);
        check({tag, "_busy"}, busy_out, 1'b0);
        check({tag, "_first"}, digit_first_out, 1'b0);
        check({tag, "_last"}, digit_last_out, 1'b0);
        check({tag, "_digit"}, digit_out, 16'h0000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [175:0] pat;
        logic [M-1:0] b_a;
        logic [M-1:0] b_b;
        int n;

        rst_n = 1'b0;
        b_valid_in = 1'b0;
        b_in = '0;
        digit_hold_in = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_before_first_edge", b_ready_out, 1'b0);
        tick();
        check("ready_after_first_edge", b_ready_out, 1'b1);

        // T1: B = 1
        clear_logs();
        send(163'h1);
        wait_idle();
        check("t1_first_count", first_q.size(), 1);
        check("t1_latency", (first_q.size() > 0 && acc_q.size() > 0) ? first_q[0] - acc_q[0] : -1, 2);
        check("t1_span", (first_q.size() > 0 && last_q.size() > 0) ? last_q[0] - first_q[0] + 1 : -1, 11);
        check("t1_valid_cycles", vcount, 11);

        // T2: all ones
        clear_logs();
        send({M{1'b1}});
        wait_idle();
        check("t2_busy_cycles", bcount, 11);
        check("t2_valid_cycles", vcount, 11);

        // T3: 5A pattern, 3-cycle hold after digit 4
        clear_logs();
        pat = {11{16'h5A5A}};
        send(pat[M-1:0]);
        wait_valid_count(5);
        digit_hold_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        digit_hold_in = 1'b0;
        wait_idle();
        check("t3_span", (first_q.size() > 0 && last_q.size() > 0) ? last_q[0] - first_q[0] + 1 : -1, 14);
        check("t3_valid_cycles", vcount, 11);

        // T4: two operands, valid held high
        clear_logs();
        b_a = rand_b();
        b_b = rand_b();
        accept_one(b_a);
        accept_one(b_b);
        b_valid_in = 1'b0;
        wait_idle();
        check("t4_first_count", first_q.size(), 2);
`ifdef FEEDER_PRELOAD_EN
        check("t4_gapless", (first_q.size() > 1 && last_q.size() > 0) ? first_q[1] - last_q[0] : -1, 1);
`else
        check("t4_first_spacing", (first_q.size() > 1) ? first_q[1] - first_q[0] : -1, 13);
        check("t4_ready_while_streaming", rb_overlap, 0);
`endif

        // T5: reset while digit 6 is on the output
        clear_logs();
        send(rand_b());
        wait_valid_count(7);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_outputs_zero("midreset");
        tick();
        check("t5_ready_after_release", b_ready_out, 1'b1);
        repeat (15) tick();
        check("t5_no_more_digits", vcount, 7);
        send(rand_b());
        wait_idle();
        check("t5_restream_digits", vcount, 18);
        check("t5_restream_last", last_q.size(), 1);

        // T6: b_in churns every cycle with valid held high
        clear_logs();
        b_valid_in = 1'b1;
        for (int i = 0; i < 40; i++) begin
            b_in = rand_b();
            tick();
        end
        b_valid_in = 1'b0;
        wait_idle();
        check("t6_multiple_accepts", acc_q.size() >= 2, 1'b1);
        check("t6_digit_total", vcount, 11 * acc_q.size());

        // T7: random operands under random stalls
        clear_logs();
        for (int op = 0; op < 4; op++) begin
            send(rand_b());
            n = 0;
            while ((q_exp.size() != 0 || busy_out) && n < 300) begin
                digit_hold_in = ($urandom_range(0, 3) == 0);
                tick();
                n++;
            end
            digit_hold_in = 1'b0;
            wait_idle();
        end
        check("t7_valid_cycles", vcount, 44);
        check("t7_last_count", last_q.size(), 4);

        check("scoreboard_drained", q_exp.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
